// File: rtl/multicycle_sequencer_pkg.sv
// rtl/multicycle_sequencer_pkg.sv - shared opcodes, control encodings and state type
package multicycle_sequencer_pkg;

  localparam logic [3:0] OP_LW   = 4'b0000;
  localparam logic [3:0] OP_SW   = 4'b0001;
  localparam logic [3:0] OP_R_LO = 4'b0010;
  localparam logic [3:0] OP_R_HI = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [1:0] ALU_RTYPE = 2'b00;
  localparam logic [1:0] ALU_CMP   = 2'b01;
  localparam logic [1:0] ALU_ADDR  = 2'b10;
  localparam logic [1:0] ALU_JMP   = 2'b11;

  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_ADDR, S_MEM_RD, S_MEM_WR,
    S_WB_MEM, S_EXEC_R, S_WB_R, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return (op >= OP_R_LO) && (op <= OP_R_HI);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// rtl/multicycle_sequencer_if.sv - datapath/memory control bundle between sequencer and datapath
interface multicycle_sequencer_if #(
  parameter int CNT_W = 16,
  parameter int OP_W  = 4
) ();
  logic             run;
  logic [OP_W-1:0]  Opcode;
  logic             zero;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_write;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic [1:0]       ALUop;
  logic             ALUsrc;
  logic             regDest;
  logic             regW;
  logic             memread;
  logic             memwrite;
  logic             memToReg;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] instret;

  modport master (
    input  run, Opcode, zero, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, pc_src, ALUop, ALUsrc, regDest,
           regW, memread, memwrite, memToReg, halted, illegal, instret
  );

  modport slave (
    output run, Opcode, zero, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, pc_src, ALUop, ALUsrc, regDest,
           regW, memread, memwrite, memToReg, halted, illegal, instret
  );
endinterface

// File: rtl/seq_retire_counter.sv
// rtl/seq_retire_counter.sv - wrapping retired-instruction counter
module seq_retire_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - fetch/decode/execute/memory/writeback control FSM
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int OP_W  = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  multicycle_sequencer_if.master bus
);

  state_t          state;
  state_t          next;
  logic [OP_W-1:0] op_q;
  logic            retire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= '0;
    end else begin
      state <= next;
      if (state == S_DECODE) op_q <= bus.Opcode;
    end
  end

  always_comb begin
    next         = state;
    retire       = 1'b0;
    bus.imem_req = 1'b0;
    bus.ir_write = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_src   = PC_INC;
    bus.ALUop    = ALU_RTYPE;
    bus.ALUsrc   = 1'b0;
    bus.regDest  = 1'b0;
    bus.regW     = 1'b0;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.memToReg = 1'b0;
    bus.halted   = 1'b0;
    bus.illegal  = 1'b0;
    case (state)
      S_IDLE: if (bus.run) next = S_FETCH;
      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          next         = S_DECODE;
        end
      end
      S_DECODE: begin
        if (bus.Opcode == OP_LW || bus.Opcode == OP_SW) next = S_ADDR;
        else if (is_rtype(bus.Opcode))                  next = S_EXEC_R;
        else if (bus.Opcode == OP_BEQ || bus.Opcode == OP_BNE) next = S_BRANCH;
        else if (bus.Opcode == OP_JMP)                  next = S_JUMP;
        else if (bus.Opcode == OP_HALT)                 next = S_HALT;
        else begin
          bus.illegal = 1'b1;
          next        = S_FETCH;
        end
      end
      S_ADDR: begin
        bus.ALUop  = ALU_ADDR;
        bus.ALUsrc = 1'b1;
        next       = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        bus.memread = 1'b1;
        bus.ALUop   = ALU_ADDR;
        bus.ALUsrc  = 1'b1;
        if (bus.dmem_ready) next = S_WB_MEM;
      end
      S_MEM_WR: begin
        bus.memwrite = 1'b1;
        bus.ALUop    = ALU_ADDR;
        bus.ALUsrc   = 1'b1;
        if (bus.dmem_ready) begin
          retire = 1'b1;
          next   = S_FETCH;
        end
      end
      S_WB_MEM: begin
        bus.regW     = 1'b1;
        bus.memToReg = 1'b1;
        retire       = 1'b1;
        next         = S_FETCH;
      end
      S_EXEC_R: next = S_WB_R;
      S_WB_R: begin
        bus.regW    = 1'b1;
        bus.regDest = 1'b1;
        retire      = 1'b1;
        next        = S_FETCH;
      end
      S_BRANCH: begin
        // beq takes the branch on zero, bne on not-zero
        bus.ALUop    = ALU_CMP;
        bus.pc_src   = PC_BRANCH;
        bus.pc_write = (op_q == OP_BEQ) ? bus.zero : !bus.zero;
        retire       = 1'b1;
        next         = S_FETCH;
      end
      S_JUMP: begin
        bus.ALUop    = ALU_JMP;
        bus.pc_src   = PC_JUMP;
        bus.pc_write = 1'b1;
        retire       = 1'b1;
        next         = S_FETCH;
      end
      S_HALT:  bus.halted = 1'b1;
      default: next = S_IDLE;
    endcase
  end

  seq_retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .count (bus.instret)
  );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - randomized check of the sequencer against an instruction-timeline model
module tb_multicycle_sequencer;

  localparam logic [14:0] E_IMEM = 15'h4000, E_IRW = 15'h2000, E_PCW = 15'h1000;
  localparam logic [14:0] E_SRC_J = 15'h0800, E_SRC_BR = 15'h0400;
  localparam logic [14:0] E_ALU_JMP = 15'h0300, E_ALU_ADDR = 15'h0200, E_ALU_CMP = 15'h0100;
  localparam logic [14:0] E_SRC = 15'h0080, E_RD = 15'h0040, E_RW = 15'h0020;
  localparam logic [14:0] E_MR = 15'h0010, E_MW = 15'h0008, E_M2R = 15'h0004;
  localparam logic [14:0] E_HALT = 15'h0002, E_ILL = 15'h0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_sequencer_if #(.CNT_W(16)) bus ();
  multicycle_sequencer_if #(.CNT_W(4))  sbus ();

  multicycle_sequencer #(.CNT_W(16)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  multicycle_sequencer #(.CNT_W(4))  sdut (.clk(clk), .rst_n(rst_n), .bus(sbus));

  assign sbus.run        = bus.run;
  assign sbus.Opcode     = bus.Opcode;
  assign sbus.zero       = bus.zero;
  assign sbus.imem_ready = bus.imem_ready;
  assign sbus.dmem_ready = bus.dmem_ready;

  logic [14:0] dut_vec, sdut_vec;
  assign dut_vec  = {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.ALUop, bus.ALUsrc,
                     bus.regDest, bus.regW, bus.memread, bus.memwrite, bus.memToReg, bus.halted, bus.illegal};
  assign sdut_vec = {sbus.imem_req, sbus.ir_write, sbus.pc_write, sbus.pc_src, sbus.ALUop, sbus.ALUsrc,
                     sbus.regDest, sbus.regW, sbus.memread, sbus.memwrite, sbus.memToReg, sbus.halted, sbus.illegal};

  int          n_chk = 0;
  int          n_fail = 0;
  int          retired = 0;
  int          rd_cyc = 0;
  logic        chk_en = 1'b0;
  logic [14:0] exp_out = '0;
  logic [31:0] exp_cnt = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("strobes", {17'd0, dut_vec}, {17'd0, exp_out});
      check("instret", {16'd0, bus.instret}, {16'd0, exp_cnt[15:0]});
      check("small_strobes", {17'd0, sdut_vec}, {17'd0, exp_out});
      check("small_instret", {28'd0, sbus.instret}, {28'd0, exp_cnt[3:0]});
      if (bus.memread) rd_cyc++;
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [3:0] rop();
    return 4'($urandom);
  endfunction

  // One clock cycle: apply inputs, state what the outputs must be this cycle.
  task automatic cyc(input logic [14:0] e, input logic ir, input logic dr, input logic [3:0] op,
                     input logic z, input logic run, input logic ret);
    bus.imem_ready = ir;
    bus.dmem_ready = dr;
    bus.Opcode     = op;
    bus.zero       = z;
    bus.run        = run;
    exp_out        = e;
    exp_cnt        = retired;
    @(posedge clk);
    #1;
    if (ret) retired++;
  endtask

  // Whole instruction from FETCH entry back to the next FETCH (or into HALT).
  task automatic do_instr(input logic [3:0] op, input logic z, input int iw, input int dw);
    for (int i = 0; i < iw; i++) cyc(E_IMEM, 1'b0, rb(), rop(), rb(), rb(), 1'b0);
    cyc(E_IMEM | E_IRW | E_PCW, 1'b1, rb(), rop(), rb(), rb(), 1'b0);
    cyc((op == 4'hD || op == 4'hE) ? E_ILL : 15'h0, rb(), rb(), op, rb(), rb(), 1'b0);
    if (op == 4'h0 || op == 4'h1) begin
      logic [14:0] m;
      m = E_ALU_ADDR | E_SRC | ((op == 4'h0) ? E_MR : E_MW);
      cyc(E_ALU_ADDR | E_SRC, rb(), rb(), rop(), rb(), rb(), 1'b0);
      for (int i = 0; i < dw; i++) cyc(m, rb(), 1'b0, rop(), rb(), rb(), 1'b0);
      cyc(m, rb(), 1'b1, rop(), rb(), rb(), op == 4'h1);
      if (op == 4'h0) cyc(E_RW | E_M2R, rb(), rb(), rop(), rb(), rb(), 1'b1);
    end else if (op >= 4'h2 && op <= 4'h9) begin
      cyc(15'h0, rb(), rb(), rop(), rb(), rb(), 1'b0);
      cyc(E_RW | E_RD, rb(), rb(), rop(), rb(), rb(), 1'b1);
    end else if (op == 4'hA || op == 4'hB) begin
      cyc(E_ALU_CMP | E_SRC_BR | (((op == 4'hA) == z) ? E_PCW : 15'h0),
          rb(), rb(), rop(), z, rb(), 1'b1);
    end else if (op == 4'hC) begin
      cyc(E_ALU_JMP | E_SRC_J | E_PCW, rb(), rb(), rop(), rb(), rb(), 1'b1);
    end else if (op == 4'hF) begin
      for (int i = 0; i < 20; i++) cyc(E_HALT, rb(), rb(), rop(), rb(), 1'(i % 2), 1'b0);
    end
  endtask

  task automatic start_from_idle();
    for (int i = 0; i < 3; i++) cyc(15'h0, rb(), rb(), rop(), rb(), 1'b0, 1'b0);
    cyc(15'h0, rb(), rb(), rop(), rb(), 1'b1, 1'b0);
  endtask

  initial begin
    logic [3:0] op;
    bus.run = 1'b0; bus.Opcode = '0; bus.zero = 1'b0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_strobes", {17'd0, dut_vec}, 32'd0);
    check("reset_instret", {16'd0, bus.instret}, 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    start_from_idle();

    do_instr(4'h2, 1'b0, 0, 0);
    check("rtype_instret", {16'd0, bus.instret}, 32'd1);
    rd_cyc = 0;
    do_instr(4'h0, 1'b0, 0, 3);
    check("lw_memread_cycles", rd_cyc, 32'd4);
    check("lw_instret", {16'd0, bus.instret}, 32'd2);
    do_instr(4'hA, 1'b1, 0, 0);
    do_instr(4'hA, 1'b0, 1, 0);
    do_instr(4'hB, 1'b0, 0, 0);
    do_instr(4'hD, 1'b0, 0, 0);
    check("illegal_instret", {16'd0, bus.instret}, 32'd5);
    check("back_in_fetch", {31'd0, bus.imem_req}, 32'd1);

    for (int n = 0; n < 300; n++) begin
      do op = rop(); while (op == 4'hF);
      do_instr(op, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    do_instr(4'hF, 1'b0, 1, 0);
    check("halted_held", {31'd0, bus.halted}, 32'd1);

    #1;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("async_reset_strobes", {17'd0, dut_vec}, 32'd0);
    check("async_reset_instret", {16'd0, bus.instret}, 32'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    retired = 0;
    chk_en  = 1'b1;
    start_from_idle();
    do_instr(4'hC, 1'b0, 0, 0);
    check("post_reset_instret", {16'd0, bus.instret}, 32'd1);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
